// File: rtl/joy_select_scheduler.sv
// Megadrive pad scanner: drives an external parallel-load shifter through eight
// SELECT phases per frame, decodes 3/6-button pads and commits results atomically.
module joy_select_scheduler #(
  parameter int CLK_DIV      = 4,
  parameter int SETTLE_TICKS = 8,
  parameter int GAP_TICKS    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load_n,
  output logic        joy_sel,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        joy1_md,
  output logic        joy2_md,
  output logic        joy1_6b,
  output logic        joy2_6b,
  output logic        frame_done
);

  // state      | meaning
  // S_IDLE     | waiting for scan_en on a tick
  // S_SETTLE   | joy_sel held stable for SETTLE_TICKS ticks
  // S_LOAD     | joy_load_n low for one tick
  // S_SHIFT_LO | joy_clk low, joy_data sampled into bit n
  // S_SHIFT_HI | joy_clk high, n advances; decode after bit 15
  // S_GAP      | idle ticks between frames
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_GAP
  } state_t;

  localparam int DW      = $clog2(CLK_DIV);
  localparam int CNT_MAX = (SETTLE_TICKS > GAP_TICKS) ? SETTLE_TICKS : GAP_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [DW-1:0] DIV_INIT    = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0] GAP_INIT    = CW'(GAP_TICKS - 1);
  localparam logic [13:0]   OUT_RST     = {2'b00, 12'hFFF};

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      phase_q, phase_d;
  logic [3:0]      bit_q, bit_d;
  logic [5:0]      f1_q, f1_d, f2_q, f2_d;
  logic            sel_q, sel_d;
  logic [13:0]     pad1_q, pad1_d, pad2_q, pad2_d;
  logic [13:0]     out1_q, out1_d, out2_q, out2_d;
  logic            frame_done_q, frame_done_d;
  logic            tick;

  // Pad record is {6b, md, MXYZ SACB RLDU}; f is {P9, P6, R, L, D, U}.
  function automatic logic [13:0] decode_pad(input logic [2:0] ph, input logic [5:0] f,
                                             input logic [13:0] cur);
    logic [13:0] r;
    r = cur;
    case (ph)
      3'd0: r[5:0] = f;
      3'd1: begin
        r[12] = ~f[2] & ~f[3];
        r[7]  = r[12] ? f[5] : 1'b1;
        r[6]  = r[12] ? f[4] : 1'b1;
      end
      3'd5: r[13] = (f[3:0] == 4'b0000) & cur[12];
      3'd6: r[11:8] = cur[13] ? f[3:0] : 4'hF;
      default: ;
    endcase
    return r;
  endfunction

  assign tick = (div_q == '0);

  always_comb begin
    div_d        = tick ? DIV_INIT : div_q - 1'b1;
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    f1_d         = f1_q;
    f2_d         = f2_q;
    sel_d        = sel_q;
    pad1_d       = pad1_q;
    pad2_d       = pad2_q;
    out1_d       = out1_q;
    out2_d       = out2_q;
    frame_done_d = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (scan_en) begin
            state_d = S_SETTLE;
            phase_d = 3'd0;
            sel_d   = 1'b1;
            cnt_d   = SETTLE_INIT;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_LOAD;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_LOAD: begin
          state_d = S_SHIFT_LO;
          bit_d   = 4'd0;
        end
        S_SHIFT_LO: begin
          state_d = S_SHIFT_HI;
          // bits 2..7 and 10..15 share the low three index bits 2..7
          if (bit_q[2:0] >= 3'd2) begin
            if (bit_q[3]) f2_d[bit_q[2:0] - 3'd2] = joy_data;
            else          f1_d[bit_q[2:0] - 3'd2] = joy_data;
          end
        end
        S_SHIFT_HI: begin
          if (bit_q == 4'd15) begin
            pad1_d = decode_pad(phase_q, f1_q, pad1_q);
            pad2_d = decode_pad(phase_q, f2_q, pad2_q);
            if (phase_q == 3'd7) begin
              state_d      = S_GAP;
              cnt_d        = GAP_INIT;
              out1_d       = pad1_d;
              out2_d       = pad2_d;
              frame_done_d = 1'b1;
            end else begin
              state_d = S_SETTLE;
              phase_d = phase_q + 3'd1;
              sel_d   = phase_q[0];
              cnt_d   = SETTLE_INIT;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = S_SHIFT_LO;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            phase_d = 3'd0;
            sel_d   = 1'b1;
            if (scan_en) begin
              state_d = S_SETTLE;
              cnt_d   = SETTLE_INIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      phase_q      <= 3'd0;
      bit_q        <= 4'd0;
      f1_q         <= '1;
      f2_q         <= '1;
      sel_q        <= 1'b1;
      pad1_q       <= '1;
      pad2_q       <= '1;
      out1_q       <= OUT_RST;
      out2_q       <= OUT_RST;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      f1_q         <= f1_d;
      f2_q         <= f2_d;
      sel_q        <= sel_d;
      pad1_q       <= pad1_d;
      pad2_q       <= pad2_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign joy_clk    = (state_q == S_SHIFT_HI);
  assign joy_load_n = (state_q != S_LOAD);
  assign joy_sel    = sel_q;
  assign joy1_o     = out1_q[11:0];
  assign joy1_md    = out1_q[12];
  assign joy1_6b    = out1_q[13];
  assign joy2_o     = out2_q[11:0];
  assign joy2_md    = out2_q[12];
  assign joy2_6b    = out2_q[13];
  assign frame_done = frame_done_q;

endmodule

// File: doc/joy_select_scheduler.md
JOY_SELECT_SCHEDULER -- requirements
Module: joy_select_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per scheduler tick (>=2).
REQ-002 The block SHALL have parameter SETTLE_TICKS, default 8, meaning ticks that joy_sel is held stable before each load.
REQ-003 The block SHALL have parameter GAP_TICKS, default 64, meaning idle ticks between frames.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 scan_en  input  1  enables frame scheduling.
REQ-007 joy_data  input  1  serial data from the external shifter.
REQ-008 joy_clk  output  1  shifter clock.
REQ-009 joy_load_n  output  1  shifter parallel load, active low.
REQ-010 joy_sel  output  1  shared Megadrive SELECT line to both ports.
REQ-011 joy1_o, joy2_o  output  12  MXYZ SACB RLDU, active low.
REQ-012 joy1_md, joy2_md  output  1  3/6-button pad detected.
REQ-013 joy1_6b, joy2_6b  output  1  6-button pad detected.
REQ-014 frame_done  output  1  one-clk strobe when outputs are committed.

Function
REQ-015 A free-running divider SHALL assert an internal tick every CLK_DIV clk cycles; FSM state changes and output pin changes SHALL occur only on tick.
REQ-016 The FSM SHALL have states IDLE, SETTLE, LOAD, SHIFT_LO, SHIFT_HI, GAP.
REQ-017 IDLE -> SETTLE, phase=0, on a tick with scan_en=1.
REQ-018 SETTLE lasts SETTLE_TICKS ticks, then LOAD; LOAD drives joy_load_n=0 for exactly 1 tick, then SHIFT_LO.
REQ-019 SHIFT_LO: joy_clk=0, sample joy_data into bit[n]; SHIFT_HI: joy_clk=1, n increments; 16 bits (n=0..15) per phase, 33+SETTLE_TICKS ticks per phase including LOAD.
REQ-020 After bit 15 the phase SHALL be decoded, then phase increments; after phase 7 -> GAP.
REQ-021 joy_sel SHALL equal NOT phase[0] (1 in phases 0,2,4,6; 0 in phases 1,3,5,7) and change only on entry to SETTLE.
REQ-022 Serial bit map per phase: bits 2..7 = joy1 {P9,P6,R,L,D,U}; bits 10..15 = joy2, same order; other bits ignored.
REQ-023 Phase 0 decode: capture U,D,L,R,B(P6),C(P9) per controller.
REQ-024 Phase 1 decode: L=0 and R=0 -> md=1, A=P6, Start=P9; otherwise md=0, A=Start=1.
REQ-025 Phase 5 decode: U=D=L=R=0 and md=1 -> 6b=1, otherwise 6b=0.
REQ-026 Phase 6 decode, only if 6b=1: Z=U, Y=D, X=L, M=R; if 6b=0, MXYZ=1111.
REQ-027 Phases 2,3,4,7 SHALL toggle joy_sel only; data ignored.
REQ-028 Decoded values SHALL be held in shadow registers and copied to joy*_o, joy*_md, joy*_6b atomically on GAP entry, with frame_done pulsed for exactly 1 clk in the same cycle.
REQ-029 GAP lasts GAP_TICKS ticks; then SETTLE if scan_en=1, else IDLE.
REQ-030 scan_en deasserted mid-frame SHALL NOT abort the frame; it takes effect at GAP exit.
REQ-031 Frame length SHALL be 8*(SETTLE_TICKS+33)+GAP_TICKS ticks (392 ticks = 1568 clk at defaults).

Reset
REQ-032 reset=1 SHALL immediately force: IDLE, divider=0, phase=0, n=0, joy_clk=0, joy_load_n=1, joy_sel=1, joy*_o=12'hFFF, md=0, 6b=0, frame_done=0, shadows=all ones.
REQ-033 Reset asserted mid-frame SHALL discard partial data; no output change occurs except the reset values.

Verification
REQ-034 Defaults, scan_en=1, joy_data constantly 1 -> frame_done every 1568 clk, joy1_o=joy2_o=12'hFFF, md=6b=0.
REQ-035 Model 3-button pad on joy1 (A pressed, phase 1 bits 4,5=0) -> joy1_md=1, joy1_6b=0, joy1_o=12'hFBF, joy2 unaffected.
REQ-036 Model 6-button pad on joy2, X and Start pressed -> joy2_6b=1, joy2_o=12'hB7F.
REQ-037 joy_sel and joy_load_n checked per phase: sel sequence 1,0,1,0,1,0,1,0, one load pulse of CLK_DIV clk per phase, 16 joy_clk pulses per phase.
REQ-038 reset at phase 4 bit 9 -> pins/outputs return to reset values within the same cycle; next frame decodes cleanly.
REQ-039 scan_en dropped in phase 3 -> frame completes, frame_done pulses once, FSM in IDLE, joy_sel=1.
